// File: rtl/dot_accumulate.sv
// dot_accumulate: sums groups of LEN signed products into a saturating
// ACC_WIDTH accumulator and emits each dot product as a one-cycle pulse.
//
// Stream protocol: there is no ready. A product is consumed on every rising
// edge where in_valid is high and in_clear and reset are low. out_valid is a
// single-cycle strobe that qualifies a freshly updated out_S/out_ovf pair,
// and those two stay unchanged until the next strobe.
module dot_accumulate #(
   parameter int P_WIDTH   = 32,
   parameter int ACC_WIDTH = 40,
   parameter int LEN       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [P_WIDTH-1:0]   in_P,
   input  logic                 in_clear,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_S,
   output logic                 out_ovf,
   output logic                 busy
);

   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [CW-1:0]        cnt;
   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf_s;

   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH-1:0] sum;
   logic                 add_ovf;
   logic                 first;
   logic                 last;
   logic [ACC_WIDTH-1:0] next_val;
   logic                 next_ovf;

   // Sign-extend the incoming product to accumulator width.
   generate
      if (ACC_WIDTH > P_WIDTH) begin : g_ext
         assign p_ext = {{(ACC_WIDTH-P_WIDTH){in_P[P_WIDTH-1]}}, in_P};
      end else begin : g_noext
         assign p_ext = in_P;
      end
   endgenerate

   // Saturating add: overflow only when both operands share a sign and the
   // raw sum's sign differs; clamp toward the operands' sign.
   always_comb begin
      sum      = acc + p_ext;
      add_ovf  = (acc[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
      first    = (cnt == '0);
      last     = (cnt == LAST);
      next_val = sum;
      next_ovf = ovf_s | add_ovf;
      if (first) begin
         // A group starts fresh from the product itself, never saturating.
         next_val = p_ext;
         next_ovf = 1'b0;
      end else if (add_ovf) begin
         next_val = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
   end

   // Group counter, partial sum, sticky flag and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         acc       <= '0;
         ovf_s     <= 1'b0;
         out_valid <= 1'b0;
         out_S     <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_clear) begin
            cnt   <= '0;
            acc   <= '0;
            ovf_s <= 1'b0;
         end else if (in_valid) begin
            acc   <= next_val;
            ovf_s <= next_ovf;
            if (last) begin
               cnt       <= '0;
               out_S     <= next_val;
               out_ovf   <= next_ovf;
               out_valid <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // busy follows the registered count, so it falls on the out_valid edge.
   assign busy = (cnt != '0);

endmodule

// File: tb/tb_dot_accumulate.sv
// Directed bench for dot_accumulate: default 40-bit instance plus a 33-bit
// instance for the saturation cases.
module tb_dot_accumulate;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_P;
   logic        in_clear;
   logic        out_valid;
   logic [39:0] out_S;
   logic        out_ovf;
   logic        busy;

   logic        s_valid;
   logic [31:0] s_P;
   logic        s_clear;
   logic        s_out_valid;
   logic [32:0] s_out_S;
   logic        s_out_ovf;
   logic        s_busy;

   int total;
   int bad;
   int pulses;
   int s_pulses;

   dot_accumulate dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_P      (in_P),
      .in_clear  (in_clear),
      .out_valid (out_valid),
      .out_S     (out_S),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   dot_accumulate #(.P_WIDTH(32), .ACC_WIDTH(33), .LEN(8)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_valid),
      .in_P      (s_P),
      .in_clear  (s_clear),
      .out_valid (s_out_valid),
      .out_S     (s_out_S),
      .out_ovf   (s_out_ovf),
      .busy      (s_busy)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse monitors, sampled away from the active edge.
   always @(negedge clk) begin
      if (out_valid) pulses++;
      if (s_out_valid) s_pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] p);
      in_valid = 1'b1;
      in_P     = p;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic s_push(input logic [31:0] p);
      s_valid = 1'b1;
      s_P     = p;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   int mix_p[8] = '{1000, -3000, 0, 5, -5, 7, -1073709056, 1073741824};
   int mix_g[8] = '{0, 1, 0, 3, 2, 0, 1, 3};
   int base;

   initial begin
      total = 0; bad = 0; pulses = 0; s_pulses = 0;
      reset = 1'b1; in_valid = 1'b0; in_P = '0; in_clear = 1'b0;
      s_valid = 1'b0; s_P = '0; s_clear = 1'b0;
      #1;
      idle();
      idle();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_S",     64'(out_S),     64'd0);
      chk("rst_ovf",   64'(out_ovf),   64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      reset = 1'b0;
      idle();

      // Group of eight 56s.
      for (int i = 0; i < 8; i++) begin
         push(32'd56);
         if (i < 7) begin
            chk("g8_busy",   64'(busy),      64'd1);
            chk("g8_nopulse", 64'(out_valid), 64'd0);
         end
      end
      chk("g8_valid", 64'(out_valid), 64'd1);
      chk("g8_S",     64'(out_S),     64'd448);
      chk("g8_ovf",   64'(out_ovf),   64'd0);
      chk("g8_busy0", 64'(busy),      64'd0);
      idle();
      chk("g8_onecyc", 64'(out_valid), 64'd0);
      chk("g8_hold",   64'(out_S),     64'd448);

      // Mixed signs with gaps: -1993 + 32768 = 30775.
      base = pulses;
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < mix_g[i]; g++) begin
            idle();
            chk("mix_gapbusy", 64'(busy), 64'd1);
         end
         push(mix_p[i]);
         if (i == 0) chk("mix_hold", 64'(out_S), 64'd448);
      end
      chk("mix_valid", 64'(out_valid), 64'd1);
      chk("mix_S",     64'(out_S),     64'd30775);
      chk("mix_ovf",   64'(out_ovf),   64'd0);
      idle();
      chk("mix_pulses", 64'(pulses - base), 64'd1);

      // Saturation on the 33-bit instance.
      for (int i = 0; i < 8; i++) s_push(32'h4000_0000);
      chk("sat_valid", 64'(s_out_valid), 64'd1);
      chk("sat_S",     64'(s_out_S),     64'h0_FFFF_FFFF);
      chk("sat_ovf",   64'(s_out_ovf),   64'd1);
      for (int i = 0; i < 8; i++) s_push(32'd1);
      chk("sat_next_S",   64'(s_out_S),   64'd8);
      chk("sat_next_ovf", 64'(s_out_ovf), 64'd0);
      for (int i = 0; i < 8; i++) s_push(32'hC000_0000);
      chk("satn_S",   64'(s_out_S),   64'h1_0000_0000);
      chk("satn_ovf", 64'(s_out_ovf), 64'd1);
      idle();
      chk("sat_pulses", 64'(s_pulses), 64'd3);

      // Clear with simultaneous valid.
      base = pulses;
      for (int i = 0; i < 3; i++) push(32'd10);
      in_clear = 1'b1;
      push(32'd99);
      in_clear = 1'b0;
      chk("clr_nopulse", 64'(out_valid), 64'd0);
      chk("clr_busy",    64'(busy),      64'd0);
      chk("clr_holdS",   64'(out_S),     64'd30775);
      for (int i = 0; i < 8; i++) push(32'd2);
      chk("clr_valid", 64'(out_valid), 64'd1);
      chk("clr_S",     64'(out_S),     64'd16);
      idle();
      chk("clr_pulses", 64'(pulses - base), 64'd1);

      // Reset mid-group, then back-to-back groups.
      base = pulses;
      for (int i = 0; i < 5; i++) push(32'd4);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      chk("mrst_valid", 64'(out_valid), 64'd0);
      chk("mrst_S",     64'(out_S),     64'd0);
      chk("mrst_ovf",   64'(out_ovf),   64'd0);
      chk("mrst_busy",  64'(busy),      64'd0);
      for (int i = 0; i < 16; i++) begin
         push(32'd1);
         if (i == 7 || i == 15) begin
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_S",     64'(out_S),     64'd8);
         end else begin
            chk("b2b_nopulse", 64'(out_valid), 64'd0);
         end
         if (i == 8) chk("b2b_busy", 64'(busy), 64'd1);
      end
      idle();
      chk("b2b_pulses", 64'(pulses - base), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
